hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset, with ports as listed below.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
- ID_Branch  in  1  ID holds beq/bne.
- ID_Jump  in  1  ID holds j/jal/jr.
- Branch_Taken  in  1  ID branch comparator result, valid only when operands are forwarded.
- Ex_RegWr, Ex_MemRead  in  1 each  EX-stage write enable and load flag.
- Ex_Reg  in  5  EX-stage destination register.
- Mem_RegWr, Mem_MemRead  in  1 each  MEM-stage write enable and load flag.
- Mem_Reg  in  5  MEM-stage destination register.
- PC_Wr  out  1  PC write enable.
- IF_ID_Wr  out  1  IF/ID register write enable.
- ID_EX_Flush  out  1  inserts a bubble into ID/EX.
- IF_ID_Flush  out  1  kills the fetched instruction.
- Stall_Cnt  out  16  stall statistics; present only with HAZARD_STATS_EN.

Function
REQ-002 SHALL define the dependency match depX(r) = (X_Reg == r) && (X_Reg != 0), evaluated for r in {ID_rs, ID_rt}.
REQ-003 SHALL compute the required stall count need as follows; the first matching rule wins:
- need = 2 if ID_Branch && Ex_RegWr && Ex_MemRead && depEx.
- need = 1 if ID_Branch && Ex_RegWr && !Ex_MemRead && depEx.
- need = 1 if ID_Branch && Mem_RegWr && Mem_MemRead && depMem.
- need = 1 if !ID_Branch && Ex_MemRead && depEx.
- need = 0 otherwise.
REQ-004 SHALL use a 2-state FSM {RUN, STALL} with a 1-bit remaining-stall register rem.
REQ-005 In RUN with need = 0, SHALL drive PC_Wr = 1, IF_ID_Wr = 1, ID_EX_Flush = 0.
REQ-006 In RUN with need ≥ 1, SHALL drive PC_Wr = 0, IF_ID_Wr = 0, ID_EX_Flush = 1 combinationally in the same cycle.
- need = 1: remain in RUN.
- need = 2: move to STALL with rem = 1.
REQ-007 In STALL, SHALL drive PC_Wr = 0, IF_ID_Wr = 0, ID_EX_Flush = 1 and ignore the hazard inputs.
- When rem = 1, decrement rem.
- When rem = 0, return to RUN.
- STALL therefore lasts exactly 1 cycle for need = 2.
REQ-008 SHALL assert IF_ID_Flush = 1 only in RUN with need = 0 and (ID_Jump || (ID_Branch && Branch_Taken)); it SHALL be 0 in all other cases.
REQ-009 SHALL never assert IF_ID_Flush and ID_EX_Flush in the same cycle.
REQ-010 With simultaneous EX and MEM dependencies, SHALL apply the highest-priority rule only; the residual MEM dependency is re-evaluated on return to RUN.
REQ-011 SHALL produce no stall or flush for hazards on register 0.

Reset
REQ-012 While rst = 1, SHALL force:
- state = RUN, rem = 0;
- PC_Wr = 0, IF_ID_Wr = 0, ID_EX_Flush = 0, IF_ID_Flush = 0;
- Stall_Cnt = 0.
REQ-013 Reset asserted mid-STALL SHALL abort the stall immediately.
REQ-014 On the first clock edge after rst deasserts, SHALL evaluate from RUN.

Configuration
REQ-015 When HAZARD_STATS_EN is defined, SHALL implement Stall_Cnt as follows:
- increments by 1 on every clock edge where PC_Wr = 0 and rst = 0;
- saturates at 16'hFFFF.
REQ-016 When HAZARD_STATS_EN is undefined, SHALL omit the Stall_Cnt port and its register; all other behaviour SHALL be identical.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Load-use, non-branch: Ex_MemRead = 1, Ex_RegWr = 1, Ex_Reg = 8, ID_rs = 8 -> one cycle with PC_Wr = 0, ID_EX_Flush = 1, then PC_Wr = 1.
- Branch on EX load: ID_Branch = 1, Ex load to ID_rt = 9 -> two consecutive stall cycles (RUN then STALL), then RUN; with Branch_Taken = 1, IF_ID_Flush = 1 in the following cycle.
- Branch on EX ALU result: Ex_RegWr = 1, Ex_MemRead = 0, Ex_Reg = ID_rs = 3 -> one stall; Branch_Taken = 1 -> IF_ID_Flush pulse of exactly 1 cycle.
- Register-0 and jump: Ex_Reg = 0 with Ex_MemRead = 1 -> no stall; ID_Jump = 1 -> IF_ID_Flush = 1, PC_Wr = 1 the same cycle.
- Reset mid-STALL: assert rst during STALL -> all outputs 0 asynchronously; after release, state RUN, with no leftover stall cycle.
- HAZARD_STATS_EN defined: 3 stall cycles -> Stall_Cnt = 3; forced to 16'hFFFF plus one more stall -> stays 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage MIPS-style core.
// Detects load-use and branch-operand hazards, stalls PC and IF/ID, injects
// bubbles into ID/EX, and kills the fetched instruction on taken control flow.
// Optional stall statistics counter is enabled with `define HAZARD_STATS_EN.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_Branch,
    input  logic        ID_Jump,
    input  logic        Branch_Taken,
    input  logic        Ex_RegWr,
    input  logic        Ex_MemRead,
    input  logic [4:0]  Ex_Reg,
    input  logic        Mem_RegWr,
    input  logic        Mem_MemRead,
    input  logic [4:0]  Mem_Reg,
    output logic        PC_Wr,
    output logic        IF_ID_Wr,
    output logic        ID_EX_Flush,
    output logic        IF_ID_Flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] Stall_Cnt
`endif
);

    typedef enum logic [0:0] {StRun, StStall} state_e;

    state_e     state_q, state_d;
    logic       rem_q, rem_d;
    logic       dep_ex, dep_mem;
    logic [1:0] need;

    // Register-0 writes never create a dependency.
    assign dep_ex  = (Ex_Reg  != 5'd0) && ((Ex_Reg  == ID_rs) || (Ex_Reg  == ID_rt));
    assign dep_mem = (Mem_Reg != 5'd0) && ((Mem_Reg == ID_rs) || (Mem_Reg == ID_rt));

    // Required stall count; first matching rule wins, so a simultaneous MEM
    // dependency is left to be re-evaluated once the EX stall resolves.
    always_comb begin
        need = 2'd0;
        if (ID_Branch && Ex_RegWr && Ex_MemRead && dep_ex) begin
            need = 2'd2;
        end else if (ID_Branch && Ex_RegWr && !Ex_MemRead && dep_ex) begin
            need = 2'd1;
        end else if (ID_Branch && Mem_RegWr && Mem_MemRead && dep_mem) begin
            need = 2'd1;
        end else if (!ID_Branch && Ex_MemRead && dep_ex) begin
            need = 2'd1;
        end
    end

    // State and remaining-stall registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            rem_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next state and pipeline control outputs; all outputs held low in reset.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        PC_Wr       = 1'b0;
        IF_ID_Wr    = 1'b0;
        ID_EX_Flush = 1'b0;
        IF_ID_Flush = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StRun: begin
                    if (need == 2'd0) begin
                        PC_Wr       = 1'b1;
                        IF_ID_Wr    = 1'b1;
                        IF_ID_Flush = ID_Jump || (ID_Branch && Branch_Taken);
                    end else begin
                        ID_EX_Flush = 1'b1;
                        if (need == 2'd2) begin
                            state_d = StStall;
                            rem_d   = 1'b1;
                        end
                    end
                end
                StStall: begin
                    // Hazard inputs are ignored here. rem is always 1 on entry,
                    // so the decrement and return happen after a single cycle.
                    ID_EX_Flush = 1'b1;
                    if (rem_q) begin
                        rem_d = 1'b0;
                    end
                    state_d = StRun;
                end
                default: begin
                    state_d = StRun;
                    rem_d   = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else if (!PC_Wr && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. A behavioural model
// predicts the control outputs for each driven cycle; predictions are queued
// and compared against the DUT once its outputs have settled.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  ID_rs, ID_rt;
    logic        ID_Branch, ID_Jump, Branch_Taken;
    logic        Ex_RegWr, Ex_MemRead;
    logic [4:0]  Ex_Reg;
    logic        Mem_RegWr, Mem_MemRead;
    logic [4:0]  Mem_Reg;
    logic        PC_Wr, IF_ID_Wr, ID_EX_Flush, IF_ID_Flush;
    logic [15:0] Stall_Cnt;

    typedef struct packed {
        logic [3:0]  ctl;  // {PC_Wr, IF_ID_Wr, ID_EX_Flush, IF_ID_Flush}
        logic [15:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Model state.
    bit          m_stall = 1'b0;
    logic [15:0] m_cnt   = 16'd0;

`ifdef HAZARD_STATS_EN
    hazard_ctrl dut (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_Branch(ID_Branch), .ID_Jump(ID_Jump), .Branch_Taken(Branch_Taken),
        .Ex_RegWr(Ex_RegWr), .Ex_MemRead(Ex_MemRead), .Ex_Reg(Ex_Reg),
        .Mem_RegWr(Mem_RegWr), .Mem_MemRead(Mem_MemRead), .Mem_Reg(Mem_Reg),
        .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr), .ID_EX_Flush(ID_EX_Flush),
        .IF_ID_Flush(IF_ID_Flush), .Stall_Cnt(Stall_Cnt)
    );
`else
    hazard_ctrl dut (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_Branch(ID_Branch), .ID_Jump(ID_Jump), .Branch_Taken(Branch_Taken),
        .Ex_RegWr(Ex_RegWr), .Ex_MemRead(Ex_MemRead), .Ex_Reg(Ex_Reg),
        .Mem_RegWr(Mem_RegWr), .Mem_MemRead(Mem_MemRead), .Mem_Reg(Mem_Reg),
        .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr), .ID_EX_Flush(ID_EX_Flush),
        .IF_ID_Flush(IF_ID_Flush)
    );
    assign Stall_Cnt = 16'd0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_need();
        bit dex, dmem;
        dex  = (Ex_Reg  != 0) && (Ex_Reg  == ID_rs || Ex_Reg  == ID_rt);
        dmem = (Mem_Reg != 0) && (Mem_Reg == ID_rs || Mem_Reg == ID_rt);
        if (ID_Branch && Ex_RegWr && Ex_MemRead && dex)        return 2'd2;
        if (ID_Branch && Ex_RegWr && !Ex_MemRead && dex)       return 2'd1;
        if (ID_Branch && Mem_RegWr && Mem_MemRead && dmem)     return 2'd1;
        if (!ID_Branch && Ex_MemRead && dex)                   return 2'd1;
        return 2'd0;
    endfunction

    // One cycle: inputs already driven (at a negedge). Predict, compare after
    // settling, then advance the model across the rising edge.
    task automatic step(input string tag);
        exp_t       e;
        exp_t       got;
        string      t;
        logic [1:0] need;
        need  = model_need();
        e.cnt = m_cnt;
        if (rst)                e.ctl = 4'b0000;
        else if (m_stall)       e.ctl = 4'b0010;
        else if (need != 2'd0)  e.ctl = 4'b0010;
        else                    e.ctl = {3'b110, ID_Jump | (ID_Branch & Branch_Taken)};
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        got.ctl = {PC_Wr, IF_ID_Wr, ID_EX_Flush, IF_ID_Flush};
        got.cnt = Stall_Cnt;
        check_eq(t, {28'd0, got.ctl}, {28'd0, e.ctl});
        check_eq({t, "_flush_excl"}, {31'd0, IF_ID_Flush & ID_EX_Flush}, 32'd0);
`ifdef HAZARD_STATS_EN
        check_eq({t, "_cnt"}, {16'd0, got.cnt}, {16'd0, e.cnt});
`endif
        @(posedge clk);
        if (rst) begin
            m_stall = 1'b0;
            m_cnt   = 16'd0;
        end else begin
            if (e.ctl[3] == 1'b0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_stall = m_stall ? 1'b0 : (need == 2'd2);
        end
        @(negedge clk);
    endtask

    task automatic clr();
        ID_rs = 0; ID_rt = 0; ID_Branch = 0; ID_Jump = 0; Branch_Taken = 0;
        Ex_RegWr = 0; Ex_MemRead = 0; Ex_Reg = 0;
        Mem_RegWr = 0; Mem_MemRead = 0; Mem_Reg = 0;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step("reset");
        rst = 1'b0;
        step("idle");

        // Load-use, non-branch.
        Ex_MemRead = 1; Ex_RegWr = 1; Ex_Reg = 8; ID_rs = 8;
        step("lu_stall");
        clr();
        step("lu_resume");

        // Branch on EX load: RUN stall, STALL, then taken-branch flush.
        ID_Branch = 1; Branch_Taken = 1; ID_rt = 9;
        Ex_MemRead = 1; Ex_RegWr = 1; Ex_Reg = 9;
        step("bl_stall_run");
        step("bl_stall_st");
        Ex_MemRead = 0; Ex_RegWr = 0; Ex_Reg = 0;
        step("bl_flush");
`ifdef HAZARD_STATS_EN
        check_eq("cnt_three", {16'd0, Stall_Cnt}, 32'd3);
`endif
        clr();
        step("bl_after");

        // Branch on EX ALU result.
        ID_Branch = 1; Branch_Taken = 1; ID_rs = 3;
        Ex_RegWr = 1; Ex_Reg = 3;
        step("ba_stall");
        Ex_RegWr = 0; Ex_Reg = 0;
        step("ba_flush");
        clr();
        step("ba_pulse_end");

        // Branch on MEM load, and simultaneous EX/MEM dependencies.
        ID_Branch = 1; ID_rs = 5; Mem_RegWr = 1; Mem_MemRead = 1; Mem_Reg = 5;
        step("bm_stall");
        ID_rs = 4; Mem_Reg = 4; Ex_RegWr = 1; Ex_MemRead = 1; Ex_Reg = 4;
        step("both_run");
        step("both_st");
        Ex_RegWr = 0; Ex_MemRead = 0; Ex_Reg = 0;
        step("both_residual");
        clr();
        step("both_clear");

        // Non-branch hazards that need no stall.
        ID_rs = 6; Ex_RegWr = 1; Ex_Reg = 6;
        step("nb_alu");
        clr();
        ID_rt = 7; Mem_RegWr = 1; Mem_MemRead = 1; Mem_Reg = 7;
        step("nb_memload");
        clr();

        // Register 0 and jumps.
        Ex_MemRead = 1; Ex_RegWr = 1; Ex_Reg = 0;
        step("r0_nostall");
        ID_Branch = 1; Mem_RegWr = 1; Mem_MemRead = 1;
        step("r0_branch");
        clr();
        ID_Jump = 1;
        step("jump_flush");
        ID_rs = 2; Ex_MemRead = 1; Ex_RegWr = 1; Ex_Reg = 2;
        step("jump_lu");
        clr();
        ID_Branch = 1; Branch_Taken = 0;
        step("br_not_taken");
        clr();

        // Reset asserted mid-STALL aborts the stall.
        ID_Branch = 1; ID_rs = 10; Ex_MemRead = 1; Ex_RegWr = 1; Ex_Reg = 10;
        step("rs_enter");
        rst = 1'b1;
        step("rs_async");
        rst = 1'b0;
        clr();
        step("rs_release");

        // Random traffic over a small register range to provoke collisions.
        for (int i = 0; i < 60; i++) begin
            ID_rs = 5'($urandom_range(0, 3));      ID_rt = 5'($urandom_range(0, 3));
            ID_Branch = 1'($urandom);              ID_Jump = 1'($urandom_range(0, 3) == 0);
            Branch_Taken = 1'($urandom);
            Ex_RegWr = 1'($urandom);               Ex_MemRead = 1'($urandom);
            Ex_Reg = 5'($urandom_range(0, 3));
            Mem_RegWr = 1'($urandom);              Mem_MemRead = 1'($urandom);
            Mem_Reg = 5'($urandom_range(0, 3));
            step("rand");
        end
        clr();
        step("rand_drain");

`ifdef HAZARD_STATS_EN
        // Saturation: preload the counter at its ceiling, then stall once more.
        force dut.stall_cnt_q = 16'hFFFF;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 16'hFFFF;
        Ex_MemRead = 1; Ex_RegWr = 1; Ex_Reg = 8; ID_rs = 8;
        step("sat_stall");
        clr();
        step("sat_hold");
        check_eq("cnt_sat", {16'd0, Stall_Cnt}, 32'h0000FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
